// File: rtl/fft8_pkg.sv
// Shared constants, types and helpers for the 8-point radix-2 DIT FFT sequencer.
package fft8_pkg;

    localparam int N     = 8;
    localparam int LOG2N = 3;
    localparam int DW    = 8;

    typedef logic signed [DW-1:0] sample_t;

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        UNLOAD
    } state_t;

    // W8^k scaled by 64, k = 0..3
    localparam sample_t TW_R [4] = '{8'sd64, 8'sd45, 8'sd0, -8'sd45};
    localparam sample_t TW_I [4] = '{8'sd0, -8'sd45, -8'sd64, -8'sd45};

    function automatic logic [LOG2N-1:0] rev3(input logic [LOG2N-1:0] n);
        return {n[0], n[1], n[2]};
    endfunction

endpackage

// File: rtl/fft8_agu.sv
// Butterfly address generator: maps (stage, butterfly) to the operand pair and twiddle index.
module fft8_agu
    import fft8_pkg::*;
(
    input  logic [1:0]       s,
    input  logic [1:0]       b,
    output logic [LOG2N-1:0] top,
    output logic [LOG2N-1:0] bot,
    output logic [1:0]       k
);

    // NOTE: every output gets a default before the case so no path leaves a latch behind.
    always_comb begin
        top = '0;
        k   = '0;
        case (s)
            2'd0: begin
                top = {b, 1'b0};
                k   = 2'd0;
            end
            2'd1: begin
                top = {b[1], 1'b0, b[0]};
                k   = {b[0], 1'b0};
            end
            default: begin
                top = {1'b0, b};
                k   = b;
            end
        endcase
        // top always has bit s clear, so OR-ing the span in is the same as adding it
        bot = top | (3'b001 << s);
    end

endmodule

// File: rtl/fft8_dit_ctrl.sv
// Frame buffer, sequencing FSM and operand/twiddle muxing around an external radix-2 butterfly.
module fft8_dit_ctrl
    import fft8_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_r,
    input  logic signed [DW-1:0] in_i,
    output logic signed [DW-1:0] bf_xr0,
    output logic signed [DW-1:0] bf_xi0,
    output logic signed [DW-1:0] bf_xr1,
    output logic signed [DW-1:0] bf_xi1,
    output logic signed [DW-1:0] bf_wr,
    output logic signed [DW-1:0] bf_wi,
    input  logic signed [DW-1:0] bf_yr0,
    input  logic signed [DW-1:0] bf_yi0,
    input  logic signed [DW-1:0] bf_yr1,
    input  logic signed [DW-1:0] bf_yi1,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_r,
    output logic signed [DW-1:0] out_i,
    output logic                 out_last,
    output logic                 busy
);

    state_t           state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    sample_t          mem_r [N];
    sample_t          mem_i [N];
    logic [LOG2N-1:0] top, bot;
    logic [1:0]       tw_k;

    // One counter serves all phases: load beat, butterfly index {stage, bfly}, unload index.
    fft8_agu u_agu (
        .s   (cnt[3:2]),
        .b   (cnt[1:0]),
        .top (top),
        .bot (bot),
        .k   (tw_k)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: the buffer is intentionally not reset; every entry is rewritten in LOAD before it is read.
    always_ff @(posedge clk) begin
        if (state == LOAD && in_valid) begin
            mem_r[rev3(cnt[2:0])] <= in_r;
            mem_i[rev3(cnt[2:0])] <= in_i;
        end else if (state == COMPUTE) begin
            mem_r[top] <= bf_yr0;
            mem_i[top] <= bf_yi0;
            mem_r[bot] <= bf_yr1;
            mem_i[bot] <= bf_yi1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_r     = '0;
        out_i     = '0;
        bf_xr0    = '0;
        bf_xi0    = '0;
        bf_xr1    = '0;
        bf_xi1    = '0;
        bf_wr     = '0;
        bf_wi     = '0;

        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (cnt == 4'd7) begin
                        state_nxt = COMPUTE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
            end

            COMPUTE: begin
                busy   = 1'b1;
                bf_xr0 = mem_r[top];
                bf_xi0 = mem_i[top];
                bf_xr1 = mem_r[bot];
                bf_xi1 = mem_i[bot];
                bf_wr  = TW_R[tw_k];
                bf_wi  = TW_I[tw_k];
                if (cnt == 4'd11) begin
                    state_nxt = UNLOAD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end

            UNLOAD: begin
                out_valid = 1'b1;
                out_r     = mem_r[cnt[2:0]];
                out_i     = mem_i[cnt[2:0]];
                out_last  = (cnt == 4'd7);
                if (out_ready) begin
                    if (cnt == 4'd7) begin
                        state_nxt = LOAD;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
            end

            default: begin
                state_nxt = LOAD;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule
